// File: rtl/layer_output_serializer_pkg.sv
// Shared types and helpers for the layer output serializer.
// Imported by the serializer top.
package layer_output_serializer_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } ser_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_output_serializer.sv
// Collects one layer's parallel neuron outputs and replays
// them as a one-word-per-beat stream in neuron order.
module layer_output_serializer
  import layer_output_serializer_pkg::*;
#(
  parameter int NN        = 30,
  parameter int dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           in_valid,
  input  logic [NN*dataWidth-1:0] in_data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [dataWidth-1:0]    out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overrun
);

  localparam int IW = idx_width(NN);
  localparam logic [IW-1:0] LAST = IW'(NN - 1);

  ser_state_t state;
  ser_state_t state_n;

  logic [NN-1:0]        mask;
  logic [NN-1:0]        mask_n;
  logic [NN-1:0]        wr_en;
  logic [NN-1:0]        fill;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        idx_n;
  logic [IW-1:0]        idx_inc;
  logic [dataWidth-1:0] buffer [NN];
  logic [dataWidth-1:0] word0;
  logic [dataWidth-1:0] data_n;
  logic                 valid_n;
  logic                 last_n;
  logic                 busy_n;
  logic                 overrun_n;
  logic                 fire;

  assign fill    = mask | in_valid;
  assign fire    = out_valid & out_ready;
  assign idx_inc = idx + IW'(1);

  // Neuron 0 may land on the completing cycle itself
  assign word0 = in_valid[0] ? in_data[dataWidth-1:0]
                             : buffer[0];

  always_comb begin
    state_n   = state;
    mask_n    = mask;
    idx_n     = idx;
    wr_en     = '0;
    valid_n   = out_valid;
    data_n    = out_data;
    last_n    = out_last;
    busy_n    = busy;
    overrun_n = overrun;
    unique case (state)
      COLLECT: begin
        wr_en  = in_valid;
        mask_n = fill;
        if (&fill) begin
          state_n = SEND;
          mask_n  = '0;
          idx_n   = '0;
          valid_n = 1'b1;
          data_n  = word0;
          last_n  = (LAST == '0);
          busy_n  = 1'b1;
        end
      end
      SEND: begin
        if (|in_valid) overrun_n = 1'b1;
        if (fire) begin
          if (idx == LAST) begin
            state_n = COLLECT;
            idx_n   = '0;
            valid_n = 1'b0;
            data_n  = '0;
            last_n  = 1'b0;
            busy_n  = 1'b0;
          end else begin
            idx_n  = idx_inc;
            data_n = buffer[idx_inc];
            last_n = (idx_inc == LAST);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NN; i++) begin
      if (wr_en[i]) begin
        buffer[i] <= in_data[i*dataWidth +: dataWidth];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      mask      <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      mask      <= mask_n;
      idx       <= idx_n;
      out_valid <= valid_n;
      out_data  <= data_n;
      out_last  <= last_n;
      busy      <= busy_n;
      overrun   <= overrun_n;
    end
  end

endmodule

// File: tb/tb_layer_output_serializer.sv
// Bench for layer_output_serializer: queue model plus
// directed NN=10 and NN=1 scenarios.
module tb_layer_output_serializer;

  localparam int NN = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NN-1:0] in_valid;
  logic [NN*DW-1:0] in_data;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          overrun;

  logic          one_valid;
  logic [DW-1:0] one_data;
  logic          one_ready;
  logic          o1_valid;
  logic [DW-1:0] o1_data;
  logic          o1_last;
  logic          o1_busy;
  logic          o1_ovr;

  layer_output_serializer #(.NN(NN), .dataWidth(DW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  layer_output_serializer #(.NN(1), .dataWidth(DW)) u_one (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (one_valid),
    .in_data   (one_data),
    .out_ready (one_ready),
    .out_valid (o1_valid),
    .out_data  (o1_data),
    .out_last  (o1_last),
    .busy      (o1_busy),
    .overrun   (o1_ovr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: words per neuron, a pending mask, and the
  // queue of beats still owed to the consumer.
  logic [DW-1:0] m_buf [NN];
  logic [NN-1:0] m_mask = '0;
  logic          m_ovr = 1'b0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] log_d [$];
  logic          log_l [$];

  initial forever begin
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_mask = '0;
      m_ovr  = 1'b0;
    end else if (exp_q.size() == 0) begin
      for (int i = 0; i < NN; i++) begin
        if (in_valid[i]) begin
          m_buf[i]  = in_data[i*DW +: DW];
          m_mask[i] = 1'b1;
        end
      end
      if (&m_mask) begin
        for (int i = 0; i < NN; i++) exp_q.push_back(m_buf[i]);
        m_mask = '0;
      end
    end else begin
      if (|in_valid) m_ovr = 1'b1;
      if (out_ready) void'(exp_q.pop_front());
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("cmp_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("cmp_busy", 32'(busy), 32'(exp_q.size() != 0));
      chk("cmp_overrun", 32'(overrun), 32'(m_ovr));
      if (exp_q.size() != 0) begin
        chk("cmp_data", 32'(out_data), 32'(exp_q[0]));
        chk("cmp_last", 32'(out_last), 32'(exp_q.size() == 1));
      end
      if (out_valid && out_ready) begin
        log_d.push_back(out_data);
        log_l.push_back(out_last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [NN-1:0] v, input int base);
    in_valid = v;
    for (int i = 0; i < NN; i++) in_data[i*DW +: DW] = DW'(base + i);
    tick();
    in_valid = '0;
  endtask

  task automatic chk_log(input string name, input int base);
    chk({name, "_count"}, 32'(log_d.size()), 32'd10);
    for (int i = 0; i < NN; i++) begin
      if (i < log_d.size()) begin
        chk({name, "_data"}, 32'(log_d[i]), 32'(base + i));
        chk({name, "_last"}, 32'(log_l[i]), 32'(i == NN - 1));
      end
    end
  endtask

  initial begin
    int  bc;
    int  guard;
    bit  st2;
    bit  st7;
    logic [DW-1:0] held;
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;
    one_valid = 1'b0;
    one_data  = '0;
    one_ready = 1'b1;
    repeat (2) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    rst = 1'b0;
    tick();

    // 1: all bits in one cycle
    log_d.delete(); log_l.delete();
    load('1, 'h100);
    chk("t1_first", 32'(out_data), 32'h100);
    repeat (12) tick();
    chk_log("t1", 'h100);

    // 2: staggered arrival
    log_d.delete(); log_l.delete();
    load(10'h01F, 'h100);
    repeat (2) tick();
    chk("t2_idle", 32'(busy), 32'd0);
    load(10'h3E0, 'h100);
    chk("t2_first", 32'(out_data), 32'h100);
    bc = 0;
    repeat (12) begin
      if (busy) bc++;
      tick();
    end
    chk("t2_busy_cycles", 32'(bc), 32'd10);
    chk_log("t2", 'h100);

    // 3: backpressure on beats 2 and 7
    log_d.delete(); log_l.delete();
    load('1, 'h200);
    guard = 0;
    st2 = 0;
    st7 = 0;
    while (log_d.size() < 10 && guard < 60) begin
      if ((log_d.size() == 2 && !st2) ||
          (log_d.size() == 7 && !st7)) begin
        if (log_d.size() == 2) st2 = 1; else st7 = 1;
        out_ready = 1'b0;
        held = out_data;
        repeat (3) begin
          tick();
          chk("t3_hold", 32'(out_data), 32'(held));
        end
        chk("t3_held_value", 32'(held),
            32'(st7 ? 'h207 : 'h202));
        out_ready = 1'b1;
      end
      tick();
      guard++;
    end
    chk("t3_timeout", 32'(guard < 60), 32'd1);
    repeat (3) tick();
    chk_log("t3", 'h200);

    // 4: overrun while sending
    log_d.delete(); log_l.delete();
    load('1, 'h300);
    repeat (2) tick();
    in_valid = 10'h008;
    in_data[3*DW +: DW] = 16'hDEAD;
    tick();
    in_valid = '0;
    chk("t4_overrun", 32'(overrun), 32'd1);
    repeat (12) tick();
    chk_log("t4", 'h300);
    chk("t4_sticky", 32'(overrun), 32'd1);
    log_d.delete(); log_l.delete();
    load(10'h1FF, 'h400);
    tick();
    chk("t4_mask_clear", 32'(busy), 32'd0);
    load(10'h200, 'h500);
    chk("t4_next_first", 32'(out_data), 32'h400);
    repeat (11) tick();
    chk("t4_next_cnt", 32'(log_d.size()), 32'd10);
    if (log_d.size() == 10)
      chk("t4_next_w9", 32'(log_d[9]), 32'h509);

    // 5: reset mid-stream
    log_d.delete(); log_l.delete();
    load('1, 'h600);
    repeat (4) tick();
    chk("t5_beat4", 32'(out_data), 32'h604);
    rst = 1'b1;
    tick();
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    log_d.delete(); log_l.delete();
    load('1, 'h700);
    chk("t5_first", 32'(out_data), 32'h700);
    repeat (11) tick();
    chk_log("t5", 'h700);

    // 6: single-neuron build
    one_valid = 1'b1;
    one_data  = 16'hBEEF;
    tick();
    one_valid = 1'b0;
    chk("t6_valid", 32'(o1_valid), 32'd1);
    chk("t6_data", 32'(o1_data), 32'hBEEF);
    chk("t6_last", 32'(o1_last), 32'd1);
    chk("t6_busy", 32'(o1_busy), 32'd1);
    tick();
    chk("t6_done", 32'(o1_valid), 32'd0);
    chk("t6_idle", 32'(o1_busy), 32'd0);
    one_valid = 1'b1;
    one_data  = 16'h1234;
    tick();
    one_valid = 1'b0;
    chk("t6_rep_valid", 32'(o1_valid), 32'd1);
    chk("t6_rep_data", 32'(o1_data), 32'h1234);
    chk("t6_rep_last", 32'(o1_last), 32'd1);
    tick();
    chk("t6_rep_done", 32'(o1_valid), 32'd0);
    chk("t6_ovr", 32'(o1_ovr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
